// File: rtl/parity_arb.sv
// parity_arb: two requesters share one serial parity engine.
// A granted word is latched and its bits are folded into an accumulator,
// one bit per cycle with the LSB first. Then a registered result is
// presented for one cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req0/req1    requests, held high until the matching grant
//   data0/data1  W-bit words to check
//   odd0/odd1    parity mode per requester (0 = even, 1 = odd)
//   gnt0/gnt1    one-cycle grant pulse, high in the first SHIFT cycle
//   busy         high while a word is in service (SHIFT and DONE)
//   done         one-cycle result-valid pulse
//   par          parity result, held between done pulses
//   id           requester index of the result, held between done pulses
module parity_arb #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] data0,
  input  logic         odd0,
  input  logic         req1,
  input  logic [W-1:0] data1,
  input  logic         odd1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         par,
  output logic         id
);

  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_data;
  logic            r_odd;
  logic            r_sel;
  logic            r_last;
  logic            r_acc;
  logic [CW-1:0]   r_cnt;

  logic            w_any;
  logic            w_pick1;
  logic [W-1:0]    w_shifted;
  logic            w_bit;
  logic            w_acc_next;
  logic            w_last_bit;

  // Requester 1 wins if it is the only requester. It also wins a tie when
  // requester 0 was served last.
  assign w_any      = req0 | req1;
  assign w_pick1    = req1 & (~req0 | ~r_last);
  assign w_shifted  = r_data >> r_cnt;
  assign w_bit      = w_shifted[0];
  assign w_acc_next = r_acc ^ w_bit;
  assign w_last_bit = (r_cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_odd   <= 1'b0;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_acc   <= 1'b0;
      r_cnt   <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      par     <= 1'b0;
      id      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_pick1;
            r_data  <= w_pick1 ? data1 : data0;
            r_odd   <= w_pick1 ? odd1 : odd0;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
            gnt0    <= ~w_pick1;
            gnt1    <= w_pick1;
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          // The result is computed from the final fold. This lets par
          // be registered in the same cycle that done rises.
          if (w_last_bit) begin
            done    <= 1'b1;
            par     <= w_acc_next ^ r_odd;
            id      <= r_sel;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_last  <= r_sel;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_arb.sv
// tb_parity_arb: scoreboard bench for parity_arb with W=4.
// Each expected result (id, par) is queued when its request is driven.
// A negedge monitor pops one entry on each done pulse and compares it.
// Between done pulses the monitor checks that par and id stay stable,
// and after a reset edge it checks that they are zero.
module tb_parity_arb;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic [W-1:0] data0 = '0;
  logic         odd0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] data1 = '0;
  logic         odd1 = 1'b0;
  logic         gnt0, gnt1, busy, done, par, id;

  parity_arb #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .data0 (data0),
    .odd0  (odd0),
    .req1  (req1),
    .data1 (data1),
    .odd1  (odd1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .busy  (busy),
    .done  (done),
    .par   (par),
    .id    (id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic id;
    logic par;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic tb_last = 1'b1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic ref_par(input logic [W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  task automatic push_exp(input logic i, input logic p);
    exp_t e;
    e.id  = i;
    e.par = p;
    sb.push_back(e);
  endtask

  // Monitor. prev_rst is rst as it was sampled at the posedge between
  // two negedges, because inputs change only just after a posedge.
  logic prev_rst = 1'b1;
  logic held_par = 1'b0;
  logic held_id  = 1'b0;

  always @(negedge clk) begin
    if (gnt0 | gnt1)
      check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
    if (prev_rst) begin
      check("rst_par", {31'd0, par}, 32'd0);
      check("rst_id", {31'd0, id}, 32'd0);
      held_par = 1'b0;
      held_id  = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_id", {31'd0, id}, {31'd0, e.id});
        check("sb_par", {31'd0, par}, {31'd0, e.par});
      end
      held_par = par;
      held_id  = id;
    end else begin
      check("hold_par", {31'd0, par}, {31'd0, held_par});
      check("hold_id", {31'd0, id}, {31'd0, held_id});
    end
    prev_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) tick();
    check("reset_gnt0", {31'd0, gnt0}, 32'd0);
    check("reset_gnt1", {31'd0, gnt1}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_par", {31'd0, par}, 32'd0);
    check("reset_id", {31'd0, id}, 32'd0);
    tb_last = 1'b1;
    rst = 1'b0;
  endtask

  task automatic wait_gnt();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (gnt0 | gnt1) seen = 1'b1;
    end
    if (!seen) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check("drain", sb.size(), 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    // Single request: check exact latency and that busy covers the service.
    do_reset();
    req0 = 1'b1; data0 = 4'b1101; odd0 = 1'b0;
    push_exp(1'b0, ref_par(4'b1101, 1'b0));
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("lat_gnt0_c%0d", c), {31'd0, gnt0}, {31'd0, c == 1});
      check($sformatf("lat_gnt1_c%0d", c), {31'd0, gnt1}, 32'd0);
      check($sformatf("lat_busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 5});
      check($sformatf("lat_done_c%0d", c), {31'd0, done}, {31'd0, c == 5});
      if (c == 1) req0 = 1'b0;
    end
    drain();

    // Both requests held for four services: round-robin from requester 0.
    do_reset();
    req0 = 1'b1; data0 = 4'b1010; odd0 = 1'b0;
    req1 = 1'b1; data1 = 4'b0110; odd1 = 1'b1;
    for (int s = 0; s < 4; s++) begin
      logic w;
      w = ~tb_last;
      push_exp(w, w ? ref_par(4'b0110, 1'b1) : ref_par(4'b1010, 1'b0));
      tb_last = w;
    end
    for (int s = 0; s < 4; s++) begin
      wait_gnt();
      check($sformatf("rr_gnt1_%0d", s), {31'd0, gnt1}, {31'd0, s[0]});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    drain();

    // Requester 1 alone, twice, with idle cycles between results.
    do_reset();
    req1 = 1'b1; data1 = 4'b1111; odd1 = 1'b1;
    push_exp(1'b1, ref_par(4'b1111, 1'b1));
    wait_gnt();
    req1 = 1'b0;
    drain();
    repeat (3) tick();
    req1 = 1'b1; data1 = 4'b0000; odd1 = 1'b0;
    push_exp(1'b1, ref_par(4'b0000, 1'b0));
    wait_gnt();
    req1 = 1'b0;
    drain();

    // The latched word is immune to input changes during SHIFT.
    do_reset();
    req0 = 1'b1; data0 = 4'b1011; odd0 = 1'b0;
    push_exp(1'b0, ref_par(4'b1011, 1'b0));
    wait_gnt();
    req0 = 1'b0;
    data0 = 4'b0000;
    odd0 = 1'b1;
    drain();

    // Reset in the third SHIFT cycle abandons the word (nothing is queued).
    do_reset();
    req0 = 1'b1; data0 = 4'b0111; odd0 = 1'b0;
    wait_gnt();
    tick();
    tick();
    rst = 1'b1;
    req0 = 1'b0;
    tick();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_gnt0", {31'd0, gnt0}, 32'd0);
    check("abort_gnt1", {31'd0, gnt1}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tb_last = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    req0 = 1'b1; data0 = 4'b0001; odd0 = 1'b0;
    req1 = 1'b1; data1 = 4'b0011; odd1 = 1'b0;
    push_exp(1'b0, ref_par(4'b0001, 1'b0));
    wait_gnt();
    check("tie_after_rst_gnt0", {31'd0, gnt0}, 32'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    drain();

    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
